// File: rtl/noc_port_arbiter.sv
// Output-port arbiter: round-robin with a bounded burst lock feeding one
// registered output stage under a valid/ready handshake.
module noc_port_arbiter #(
  parameter int DataWidth = 32,
  parameter int NumIn     = 3,
  parameter int MaxBurst  = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NumIn*DataWidth-1:0] i_data,
  input  logic [NumIn-1:0]          i_data_valid,
  output logic [NumIn-1:0]          o_data_ready,
  output logic [DataWidth-1:0]      o_data,
  output logic                      o_data_valid,
  input  logic                      i_data_ready
);

  localparam int IdxW   = $clog2(NumIn);
  localparam int BurstW = $clog2(MaxBurst + 1);

  logic [IdxW-1:0]      rr_ptr;
  logic [IdxW-1:0]      lock_idx;
  logic                 locked;
  logic [BurstW-1:0]    burst_cnt;
  logic [DataWidth-1:0] data_p1;
  logic                 vld_p1;

  logic                 can_accept;
  logic                 lock_hit;
  logic                 rr_vld;
  logic [IdxW-1:0]      rr_idx;
  logic                 sel_vld;
  logic [IdxW-1:0]      sel_idx;
  logic [DataWidth-1:0] sel_flit;
  logic [BurstW-1:0]    next_cnt;
  logic [IdxW-1:0]      next_ptr;

  assign can_accept = ~vld_p1 | i_data_ready;
  assign lock_hit   = locked & i_data_valid[lock_idx] & (burst_cnt < BurstW'(MaxBurst));

  always_comb begin
    int cand;
    cand   = 0;
    rr_vld = 1'b0;
    rr_idx = '0;
    for (int i = 0; i < NumIn; i++) begin
      cand = (int'(rr_ptr) + i) % NumIn;
      if (!rr_vld && i_data_valid[IdxW'(cand)]) begin
        rr_vld = 1'b1;
        rr_idx = IdxW'(cand);
      end
    end
  end

  assign sel_vld = lock_hit | rr_vld;
  assign sel_idx = lock_hit ? lock_idx : rr_idx;

  always_comb begin
    sel_flit = '0;
    for (int k = 0; k < NumIn; k++) begin
      if (IdxW'(k) == sel_idx) sel_flit = i_data[k*DataWidth +: DataWidth];
    end
  end

  assign next_cnt = burst_cnt + BurstW'(1);
  assign next_ptr = (sel_idx == IdxW'(NumIn - 1)) ? '0 : sel_idx + IdxW'(1);

  // Strobe is held off while reset is asserted even though the empty register would accept.
  assign o_data_ready = (i_reset && can_accept && sel_vld) ? (NumIn'(1) << sel_idx) : '0;

  // Stage p1: output register and arbitration state
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      data_p1   <= '0;
      vld_p1    <= 1'b0;
      rr_ptr    <= '0;
      locked    <= 1'b0;
      lock_idx  <= '0;
      burst_cnt <= '0;
    end else if (can_accept) begin
      if (sel_vld) begin
        data_p1 <= sel_flit;
        vld_p1  <= 1'b1;
        rr_ptr  <= next_ptr;
        if (locked && sel_idx == lock_idx) begin
          burst_cnt <= next_cnt;
          locked    <= (next_cnt < BurstW'(MaxBurst));
        end else begin
          lock_idx  <= sel_idx;
          burst_cnt <= BurstW'(1);
          locked    <= (MaxBurst > 1);
        end
      end else begin
        vld_p1 <= 1'b0;
        if (locked && !i_data_valid[lock_idx]) locked <= 1'b0;
      end
    end
  end

  assign o_data       = data_p1;
  assign o_data_valid = vld_p1;

endmodule

// File: doc/noc_port_arbiter.md
# noc_port_arbiter

Output-port arbiter for the NoC switch. It shares one outgoing link among `NumIn` requesting input ports, whether they are PE ports or the inter-switch link. Arbitration is round-robin with a bounded burst lock, so one source can stream consecutive flits without starving the others. The winning flit is captured in a single registered output stage with a valid/ready handshake, and that stage drives the downstream PE or neighbouring switch at full throughput.

## Interface
- `DataWidth`, 32, flit width in bits.
- `NumIn`, 3, number of requesting inputs (2..8).
- `MaxBurst`, 4, maximum consecutive flits granted to one input while it holds the lock (≥1).

- `i_clk` input 1: the single clock; all state updates on the rising edge.
- `i_reset` input 1: asynchronous, active-low reset.
- `i_data` input NumIn*DataWidth: flit from input k in bits [k*DataWidth +: DataWidth].
- `i_data_valid` input NumIn: input k presents a flit destined for this output.
- `o_data_ready` output NumIn: one-hot or zero; accept strobe to input k.
- `o_data` output DataWidth: registered output flit.
- `o_data_valid` output 1: output register holds a flit.
- `i_data_ready` input 1: downstream accepts `o_data` this cycle.

## Operation
- Reset (i_reset=0, asynchronous):
  - Output state: `o_data_valid`=0, `o_data`=0.
  - Arbitration state: `rr_ptr`=0, `locked`=0, `lock_idx`=0, `burst_cnt`=0.
  - `o_data_ready` is 0 throughout reset.
- `can_accept` = ~`o_data_valid` | `i_data_ready`.
- Selection, combinational, evaluated only when `can_accept`=1:
  - Lock hit: if `locked` & `i_data_valid[lock_idx]` & (`burst_cnt` < MaxBurst), select `lock_idx`.
  - Otherwise select the first valid input scanning from `rr_ptr` upward, wrapping modulo NumIn.
  - No valid input means no selection.
- `o_data_ready[k]`=1 only for the selected k when `can_accept`=1; every other bit is 0.
- Transfer from input k (selected, `can_accept`=1):
  - `o_data` ← flit k; `o_data_valid` ← 1.
  - `rr_ptr` ← (k+1) mod NumIn.
  - If `locked` & k==`lock_idx`: `burst_cnt` ← `burst_cnt`+1.
  - Else: `lock_idx` ← k, `burst_cnt` ← 1, `locked` ← 1.
- Lock release:
  - `locked` ← 0 when `burst_cnt` reaches MaxBurst after a transfer.
  - `locked` ← 0 in any `can_accept` cycle where `i_data_valid[lock_idx]`=0.
  - A released lock never re-arms for the same input without a fresh round-robin win.
- MaxBurst=1 degenerates to pure round-robin.
- No transfer while `can_accept`=1: `o_data_valid` ← 0. Lock and pointer hold unless released by the rule above.
- `can_accept`=0 (output full and stalled): all state holds, `o_data` stable.
- Inputs must hold data/valid until accepted. The arbiter never drops or duplicates a flit.

## Timing
- Latency: input accepted in cycle N → `o_data`/`o_data_valid` visible in cycle N+1.
- Throughput: 1 flit/cycle while downstream is ready (drain and refill in the same cycle).
- `o_data_ready` depends combinationally on `i_data_valid` and `i_data_ready`. `o_data_valid` never depends on `i_data_ready` combinationally.
- Simultaneous drain and accept: the new flit overwrites the register in the same edge, with no bubble.
- Reset asserted mid-transfer: the flit in the register is discarded. The first post-reset grant goes to the lowest-index valid input.
- Fairness bound: any continuously valid input is granted within (NumIn-1)*MaxBurst+1 transfers.

## Test plan
- Reset with all inputs valid, reset at 0:
  - `o_data_valid`=0 and `o_data_ready`=000.
  - After release, first grant is input 0, flit visible on the next cycle.
- NumIn=3, MaxBurst=4, all inputs valid continuously, `i_data_ready`=1:
  - Grant order is 0,0,0,0,1,1,1,1,2,2,2,2,0…
  - One output flit per cycle, payloads matching source order.
- MaxBurst=1, inputs 0 and 2 valid → grants alternate 0,2,0,2; input 1 never readied.
- Input 1 holds lock with `burst_cnt`=2 and drops valid for one cycle while 0 and 2 are valid:
  - Lock releases and input 2 wins (`rr_ptr`=2).
  - Input 1 is next served only after input 2.
- Downstream stall: `i_data_ready`=0 for 5 cycles with `o_data_valid`=1:
  - `o_data` is stable and `o_data_ready`=000 for those cycles.
  - On re-assertion, drain and refill occur in the same cycle.
- Reset asserted mid-burst (input 2, `burst_cnt`=3):
  - Outputs clear immediately.
  - After release with inputs 1 and 2 valid, input 1 is granted first.
